wdt_timer: RTL and testbench



---
 rtl/wdt_pkg.sv | 16 +
 rtl/wdt_timer.sv | 89 ++++++++
 tb/tb_wdt_timer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog timer: register offsets and FSM state encoding.
package wdt_pkg;

  localparam logic [11:0] WDEN_ADDR   = 12'h100;
  localparam logic [11:0] WDLIVE_ADDR = 12'h200;
  localparam logic [11:0] WTOCNT_ADDR = 12'h300;
  localparam logic [11:0] WDCNT_ADDR  = 12'h400;
  localparam logic [11:0] WDEXP_ADDR  = 12'h500;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } wdt_state_e;

endpackage

// File: rtl/wdt_timer.sv
// Watchdog timer with a small register slave; raises a registered timeout level
// when the free-running count reaches the programmed limit.
module wdt_timer
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [11:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             timeout,
  output logic [EXP_W-1:0] expired
);

  wdt_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] wtocnt, wtocnt_nxt;
  logic [EXP_W-1:0] exp_cnt, exp_nxt;
  logic             active;
  logic             wr_den, wr_live, wr_tocnt;

  assign active   = (state != IDLE);
  assign wr_den   = wr_en && (addr == WDEN_ADDR);
  assign wr_live  = wr_en && (addr == WDLIVE_ADDR);
  assign wr_tocnt = wr_en && (addr == WTOCNT_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wtocnt  <= '0;
      exp_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wtocnt  <= wtocnt_nxt;
      exp_cnt <= exp_nxt;
    end
  end

  // Effective writes take priority over the expiry compare; ignored writes
  // (kick with bit0=0, kick while idle, read-only or unmapped) do not.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    wtocnt_nxt = wtocnt;
    exp_nxt    = exp_cnt;
    if (wr_den) begin
      state_nxt = wdata[0] ? COUNT : IDLE;
      cnt_nxt   = '0;
    end else if (wr_live && wdata[0] && active) begin
      state_nxt = COUNT;
      cnt_nxt   = '0;
    end else if (wr_tocnt) begin
      wtocnt_nxt = CNT_W'(wdata);
      if (active) begin
        state_nxt = COUNT;
        cnt_nxt   = '0;
      end
    end else if (state == COUNT) begin
      if (cnt == wtocnt) begin
        state_nxt = EXPIRED;
        if (exp_cnt != '1) exp_nxt = exp_cnt + 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // EXPIRED is a registered state, so timeout is glitch-free and drops with reset.
  assign timeout = (state == EXPIRED);
  assign expired = exp_cnt;

  always_comb begin
    rdata = '0;
    case (addr)
      WDEN_ADDR:   rdata = {31'd0, active};
      WTOCNT_ADDR: rdata = 32'(wtocnt);
      WDCNT_ADDR:  rdata = 32'(cnt);
      WDEXP_ADDR:  rdata = 32'(exp_cnt);
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_wdt_timer.sv
// Scoreboard bench for wdt_timer: each driven cycle queues its expected read data
// and timeout level, which a negedge monitor pops and compares.
module tb_wdt_timer;
  import wdt_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        wr_en = 1'b0;
  logic [11:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        timeout;
  logic [7:0]  expired;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       tag;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_to;
  } sb_t;

  sb_t sb[$];

  wdt_timer #(.CNT_W(32), .EXP_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .timeout (timeout),
    .expired (expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_rd) check({e.tag, ".rd"}, rdata, e.exp_rd);
      check({e.tag, ".to"}, 32'(timeout), 32'(e.exp_to));
    end
  end

  // Drive one cycle (inputs set just after posedge) and queue its expectation.
  task automatic cyc(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input string tag, input bit chk, input logic [31:0] exp_rd,
                     input bit exp_to);
    wr_en = wr;
    addr  = a;
    wdata = d;
    sb.push_back('{tag: tag, chk_rd: chk, exp_rd: exp_rd, exp_to: exp_to});
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string tag,
                    input logic [31:0] exp_rd, input bit exp_to);
    cyc(1'b0, a, 32'd0, tag, 1'b1, exp_rd, exp_to);
  endtask

  // Write cycle; exp_rd is the pre-write value visible at the same address.
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input string tag,
                    input logic [31:0] exp_rd, input bit exp_to);
    cyc(1'b1, a, d, tag, 1'b1, exp_rd, exp_to);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_to", 32'(timeout), 32'd0);
    check("rst_expired", 32'(expired), 32'd0);
    rst = 1'b1;

    rd(WDEN_ADDR,   "rst_wden",   32'd0, 1'b0);
    rd(WTOCNT_ADDR, "rst_wtocnt", 32'd0, 1'b0);
    rd(WDCNT_ADDR,  "rst_wdcnt",  32'd0, 1'b0);
    rd(WDEXP_ADDR,  "rst_wdexp",  32'd0, 1'b0);
    rd(WDLIVE_ADDR, "rst_wdlive", 32'd0, 1'b0);
    rd(12'h600,     "unmapped",   32'd0, 1'b0);

    // Limit 5: counter 0..5, timeout on the sixth edge after enable.
    wr(WTOCNT_ADDR, 32'd5, "t1_wto", 32'd0, 1'b0);
    wr(WDEN_ADDR,   32'd1, "t1_en",  32'd0, 1'b0);
    for (int k = 0; k <= 8; k++)
      rd(WDCNT_ADDR, $sformatf("t1_cnt%0d", k), (k < 5) ? k : 5, k >= 6);
    rd(WDEXP_ADDR,  "t1_exp",   32'd1, 1'b1);
    rd(WDEN_ADDR,   "t1_wden",  32'd1, 1'b1);
    rd(WTOCNT_ADDR, "t1_wtorb", 32'd5, 1'b1);
    wr(WDCNT_ADDR,  32'h77, "t1_ro", 32'd5, 1'b1);
    rd(WDCNT_ADDR,  "t1_ro_chk", 32'd5, 1'b1);
    wr(WDEN_ADDR,   32'd0, "t1_dis", 32'd1, 1'b1);
    rd(WDCNT_ADDR,  "t1_dis_cnt", 32'd0, 1'b0);
    rd(WDEN_ADDR,   "t1_dis_en",  32'd0, 1'b0);
    rd(WDEXP_ADDR,  "t1_dis_exp", 32'd1, 1'b0);

    // Limit 0: timeout one edge after enable.
    wr(WTOCNT_ADDR, 32'd0, "t2_wto", 32'd5, 1'b0);
    wr(WDEN_ADDR,   32'd1, "t2_en",  32'd0, 1'b0);
    rd(WDCNT_ADDR,  "t2_k0",  32'd0, 1'b0);
    rd(WDEXP_ADDR,  "t2_exp", 32'd2, 1'b1);
    wr(WDEN_ADDR,   32'd0, "t2_dis", 32'd1, 1'b1);

    // Limit 10 with a kick mid-count.
    wr(WTOCNT_ADDR, 32'd10, "t3_wto", 32'd0, 1'b0);
    wr(WDEN_ADDR,   32'd1,  "t3_en",  32'd0, 1'b0);
    for (int k = 0; k <= 7; k++)
      rd(WDCNT_ADDR, $sformatf("t3_cnt%0d", k), k, 1'b0);
    wr(WDLIVE_ADDR, 32'd1, "t3_kick", 32'd0, 1'b0);
    for (int j = 0; j <= 12; j++)
      rd(WDCNT_ADDR, $sformatf("t3_post%0d", j), (j < 10) ? j : 10, j >= 11);
    rd(WDEXP_ADDR, "t3_exp", 32'd3, 1'b1);

    // Limit rewrite while expired, kick exactly at the limit, re-enable while expired.
    wr(WTOCNT_ADDR, 32'd3, "t4_wto", 32'd10, 1'b1);
    for (int k = 0; k <= 2; k++)
      rd(WDCNT_ADDR, $sformatf("t4_cnt%0d", k), k, 1'b0);
    wr(WDLIVE_ADDR, 32'd1, "t4_kick_lim", 32'd0, 1'b0);
    rd(WDEXP_ADDR, "t4_noinc", 32'd3, 1'b0);
    for (int j = 1; j <= 3; j++)
      rd(WDCNT_ADDR, $sformatf("t4_post%0d", j), j, 1'b0);
    rd(WDEXP_ADDR, "t4_exp", 32'd4, 1'b1);
    wr(WDEN_ADDR,  32'd1, "t4_reen", 32'd1, 1'b1);
    rd(WDCNT_ADDR, "t4_reen_cnt", 32'd0, 1'b0);
    for (int k = 1; k <= 3; k++)
      rd(WDCNT_ADDR, $sformatf("t4_re%0d", k), k, 1'b0);
    rd(WDEXP_ADDR, "t4_exp2", 32'd5, 1'b1);

    // Asynchronous reset between edges while expired.
    wr_en = 1'b0;
    addr  = WDEXP_ADDR;
    #2;
    check("t5_pre_to", 32'(timeout), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_async_to", 32'(timeout), 32'd0);
    check("t5_async_exp", 32'(expired), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd(WDEN_ADDR,   "t5_wden",   32'd0, 1'b0);
    rd(WTOCNT_ADDR, "t5_wtocnt", 32'd0, 1'b0);
    rd(WDCNT_ADDR,  "t5_wdcnt",  32'd0, 1'b0);
    rd(WDEXP_ADDR,  "t5_wdexp",  32'd0, 1'b0);

    // 300 expiries with limit 0: expiry counter saturates at 255.
    wr(WTOCNT_ADDR, 32'd0, "t6_wto", 32'd0, 1'b0);
    wr(WDEN_ADDR,   32'd1, "t6_en",  32'd0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, WDEXP_ADDR, 32'd0, $sformatf("t6_idle%0d", i), 1'b1,
          (i < 255) ? i : 255, 1'b0);
      cyc(1'b1, WDLIVE_ADDR, 32'd1, $sformatf("t6_kick%0d", i), 1'b0, 32'd0, 1'b1);
    end
    rd(WDEXP_ADDR, "t6_sat",  32'd255, 1'b0);
    rd(WDEXP_ADDR, "t6_sat2", 32'd255, 1'b1);

    wr_en = 1'b0;
    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
